rob_tag_scheduler: RTL and testbench

Allocates internal tag IDs (tagid) to outgoing AXI read requests and tracks each tag until its final R beat leaves the incoming response buffer. Completed transactions are retired to the ROB strictly in allocation order. Sits beside the incoming response buffer: the AR path requests tags, and the response buffer's output handshake reports completions.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_tag_scheduler.sv | 154 +++++++++++++++
 tb/tb_rob_tag_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types for the ROB tag scheduler: slot states, AXI resp codes, and
// the resp severity merge used while accumulating a burst.
package rob_pkg;

  typedef enum logic [1:0] {
    TAG_FREE    = 2'd0,
    TAG_PENDING = 2'd1,
    TAG_DONE    = 2'd2
  } tag_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Severity order DECERR > SLVERR > EXOKAY > OKAY.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    if (a == RESP_EXOKAY || b == RESP_EXOKAY) return RESP_EXOKAY;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/rob_tag_scheduler.sv
// Tag allocator/tracker for AXI reads; retires completed tags in allocation order.
// Last beat -> retire_valid after 2 cycles; retire outputs hold while !retire_ready.
module rob_tag_scheduler
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  input  logic [ID_WIDTH-1:0]   alloc_id,
  output logic                  alloc_gnt,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  cmpl_valid,
  input  logic                  cmpl_last,
  input  logic [TAG_WIDTH-1:0]  cmpl_tag,
  input  logic [RESP_WIDTH-1:0] cmpl_resp,
  output logic                  retire_valid,
  input  logic                  retire_ready,
  output logic [TAG_WIDTH-1:0]  retire_tag,
  output logic [ID_WIDTH-1:0]   retire_id,
  output logic [RESP_WIDTH-1:0] retire_resp,
  output logic [TAG_WIDTH:0]    outstanding,
  output logic                  full,
  output logic                  empty,
  output logic                  err_unexpected
);

  localparam int NUM_TAGS = 1 << TAG_WIDTH;
  localparam int PTR_W    = TAG_WIDTH + 1;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  tag_state_e            slot_state_q [NUM_TAGS];
  tag_state_e            slot_state_d [NUM_TAGS];
  logic [ID_WIDTH-1:0]   slot_id_q    [NUM_TAGS];
  logic [ID_WIDTH-1:0]   slot_id_d    [NUM_TAGS];
  logic [RESP_WIDTH-1:0] slot_resp_q  [NUM_TAGS];
  logic [RESP_WIDTH-1:0] slot_resp_d  [NUM_TAGS];

  logic                  retire_valid_q, retire_valid_d;
  logic [TAG_WIDTH-1:0]  retire_tag_q, retire_tag_d;
  logic [ID_WIDTH-1:0]   retire_id_q, retire_id_d;
  logic [RESP_WIDTH-1:0] retire_resp_q, retire_resp_d;
  logic                  err_q, err_d;

  logic [TAG_WIDTH-1:0]  head_idx;
  logic [TAG_WIDTH-1:0]  tail_idx;
  logic [PTR_W-1:0]      count;
  logic                  full_w;
  logic                  grant;
  logic                  load;

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];
  assign count    = tail_q - head_q;
  assign full_w   = (count == PTR_W'(NUM_TAGS));
  // Grant sees only registered occupancy; a same-cycle retire frees space next cycle.
  assign grant    = alloc_req && !full_w;
  assign load     = (slot_state_q[head_idx] == TAG_DONE) && (!retire_valid_q || retire_ready);

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    slot_state_d   = slot_state_q;
    slot_id_d      = slot_id_q;
    slot_resp_d    = slot_resp_q;
    retire_valid_d = retire_valid_q;
    retire_tag_d   = retire_tag_q;
    retire_id_d    = retire_id_q;
    retire_resp_d  = retire_resp_q;
    err_d          = err_q;

    if (cmpl_valid) begin
      if (slot_state_q[cmpl_tag] == TAG_PENDING) begin
        slot_resp_d[cmpl_tag] = resp_max(slot_resp_q[cmpl_tag], cmpl_resp);
        if (cmpl_last) begin
          slot_state_d[cmpl_tag] = TAG_DONE;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (load) begin
      retire_valid_d         = 1'b1;
      retire_tag_d           = head_idx;
      retire_id_d            = slot_id_q[head_idx];
      retire_resp_d          = slot_resp_q[head_idx];
      slot_state_d[head_idx] = TAG_FREE;
      head_d                 = head_q + PTR_W'(1);
    end else if (retire_valid_q && retire_ready) begin
      retire_valid_d = 1'b0;
    end

    // The tail slot is FREE whenever a grant is possible, so it never collides
    // with the head slot being retired.
    if (grant) begin
      slot_state_d[tail_idx] = TAG_PENDING;
      slot_id_d[tail_idx]    = alloc_id;
      slot_resp_d[tail_idx]  = RESP_OKAY;
      tail_d                 = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
      retire_id_q    <= '0;
      retire_resp_q  <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        slot_state_q[i] <= TAG_FREE;
        slot_id_q[i]    <= '0;
        slot_resp_q[i]  <= '0;
      end
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      retire_valid_q <= retire_valid_d;
      retire_tag_q   <= retire_tag_d;
      retire_id_q    <= retire_id_d;
      retire_resp_q  <= retire_resp_d;
      err_q          <= err_d;
      slot_state_q   <= slot_state_d;
      slot_id_q      <= slot_id_d;
      slot_resp_q    <= slot_resp_d;
    end
  end

  assign alloc_gnt      = grant;
  assign alloc_tag      = tail_idx;
  assign retire_valid   = retire_valid_q;
  assign retire_tag     = retire_tag_q;
  assign retire_id      = retire_id_q;
  assign retire_resp    = retire_resp_q;
  assign outstanding    = count;
  assign full           = full_w;
  assign empty          = (count == '0);
  assign err_unexpected = err_q;

  a_retire_hold : assert property (@(posedge clk) disable iff (!rst)
    (retire_valid_q && !retire_ready) |=> (retire_valid_q && $stable(retire_tag_q)
      && $stable(retire_id_q) && $stable(retire_resp_q)));

  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    count <= PTR_W'(NUM_TAGS));

endmodule

// File: tb/tb_rob_tag_scheduler.sv
// Randomized + directed bench for rob_tag_scheduler against a transaction-queue model.
module tb_rob_tag_scheduler;

  logic       clk;
  logic       rst_n;
  logic       alloc_req;
  logic [3:0] alloc_id;
  logic       alloc_gnt;
  logic [3:0] alloc_tag;
  logic       cmpl_valid;
  logic       cmpl_last;
  logic [3:0] cmpl_tag;
  logic [1:0] cmpl_resp;
  logic       retire_valid;
  logic       retire_ready;
  logic [3:0] retire_tag;
  logic [3:0] retire_id;
  logic [1:0] retire_resp;
  logic [4:0] outstanding;
  logic       full;
  logic       empty;
  logic       err_unexpected;

  rob_tag_scheduler #(.ID_WIDTH(4), .TAG_WIDTH(4), .RESP_WIDTH(2)) dut (
    .clk(clk), .rst(rst_n),
    .alloc_req(alloc_req), .alloc_id(alloc_id), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_last(cmpl_last), .cmpl_tag(cmpl_tag), .cmpl_resp(cmpl_resp),
    .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_tag(retire_tag),
    .retire_id(retire_id), .retire_resp(retire_resp), .outstanding(outstanding),
    .full(full), .empty(empty), .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic [3:0] id;
    logic [1:0] resp;
    bit         done;
  } txn_t;

  // Model: in-flight transactions in allocation order, plus the one-entry output stage.
  txn_t       m_q[$];
  txn_t       exp_q[$];
  bit         m_out_vld;
  bit         m_err;
  logic [3:0] m_next;

  int checks;
  int errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_out_vld = 0;
    m_err     = 0;
    m_next    = 4'd0;
  endtask

  task automatic model_step(input bit req, input logic [3:0] id, input bit cv, input bit last,
                            input logic [3:0] ctag, input logic [1:0] cresp, input bit rdy);
    bit   grant;
    bit   load;
    bit   hit;
    txn_t t;
    grant = req && (m_q.size() < 16);
    load  = (m_q.size() > 0) && m_q[0].done && (!m_out_vld || rdy);
    if (cv) begin
      hit = 0;
      foreach (m_q[i]) begin
        if (m_q[i].tag == ctag && !m_q[i].done) begin
          hit = 1;
          if (cresp > m_q[i].resp) m_q[i].resp = cresp;
          if (last) m_q[i].done = 1;
        end
      end
      if (!hit) m_err = 1;
    end
    if (load) begin
      t = m_q.pop_front();
      exp_q.push_back(t);
      m_out_vld = 1;
    end else if (rdy && m_out_vld) begin
      m_out_vld = 0;
    end
    if (grant) begin
      t.tag  = m_next;
      t.id   = id;
      t.resp = 2'd0;
      t.done = 0;
      m_q.push_back(t);
      m_next = m_next + 4'd1;
    end
  endtask

  task automatic check_regs();
    chk("retire_valid", int'(retire_valid), int'(m_out_vld));
    chk("outstanding", int'(outstanding), m_q.size());
    chk("full", int'(full), int'(m_q.size() == 16));
    chk("empty", int'(empty), int'(m_q.size() == 0));
    chk("err_unexpected", int'(err_unexpected), int'(m_err));
  endtask

  task automatic cyc(input bit req, input logic [3:0] id, input bit cv, input bit last,
                     input logic [3:0] ctag, input logic [1:0] cresp, input bit rdy);
    @(negedge clk);
    check_regs();
    alloc_req    = req;
    alloc_id     = id;
    cmpl_valid   = cv;
    cmpl_last    = last;
    cmpl_tag     = ctag;
    cmpl_resp    = cresp;
    retire_ready = rdy;
    #1;
    chk("alloc_gnt", int'(alloc_gnt), int'(req && (m_q.size() < 16)));
    chk("alloc_tag", int'(alloc_tag), int'(m_next));
    model_step(req, id, cv, last, ctag, cresp, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(0, 4'd0, 0, 0, 4'd0, 2'd0, rdy);
  endtask

  function automatic int pick_pending();
    int idx[$];
    foreach (m_q[i]) if (!m_q[i].done) idx.push_back(i);
    if (idx.size() == 0) return -1;
    return idx[$urandom_range(0, idx.size() - 1)];
  endfunction

  task automatic check_reset();
    chk("rst_retire_valid", int'(retire_valid), 0);
    chk("rst_retire_tag", int'(retire_tag), 0);
    chk("rst_retire_id", int'(retire_id), 0);
    chk("rst_retire_resp", int'(retire_resp), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_err", int'(err_unexpected), 0);
    chk("rst_alloc_tag", int'(alloc_tag), 0);
    chk("rst_alloc_gnt", int'(alloc_gnt), 0);
  endtask

  task automatic drive_idle_inputs();
    alloc_req    = 0;
    alloc_id     = 4'd0;
    cmpl_valid   = 0;
    cmpl_last    = 0;
    cmpl_tag     = 4'd0;
    cmpl_resp    = 2'd0;
    retire_ready = 0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    drive_idle_inputs();
    #3 rst_n = 0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    #3 rst_n = 1;
  endtask

  task automatic drain();
    int p;
    for (int k = 0; k < 200 && (m_q.size() > 0 || m_out_vld); k++) begin
      p = -1;
      foreach (m_q[i]) if (p < 0 && !m_q[i].done) p = i;
      if (p >= 0) cyc(0, 4'd0, 1, 1, m_q[p].tag, 2'd0, 1);
      else        cyc(0, 4'd0, 0, 0, 4'd0, 2'd0, 1);
    end
    idle(2, 1);
  endtask

  task automatic random_phase(input int n);
    int p;
    int r;
    bit cv;
    bit last;
    logic [3:0] ctag;
    for (int k = 0; k < n; k++) begin
      r    = $urandom_range(0, 99);
      p    = pick_pending();
      cv   = 0;
      last = 0;
      ctag = 4'd0;
      if (r < 60 && p >= 0) begin
        cv   = 1;
        ctag = m_q[p].tag;
        last = ($urandom_range(0, 2) == 0);
      end else if (r < 63) begin
        cv   = 1;
        ctag = 4'($urandom_range(0, 15));
        last = 1;
      end
      cyc(bit'($urandom_range(0, 1)), 4'($urandom), cv, last, ctag,
          2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
    end
  endtask

  // Scoreboard monitor: each retire handshake pops the oldest expected retirement.
  initial begin : monitor
    txn_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && retire_valid && retire_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_extra actual_tag=%0d required=no retirement", retire_tag);
        end else begin
          e = exp_q.pop_front();
          chk("retire_tag", int'(retire_tag), int'(e.tag));
          chk("retire_id", int'(retire_id), int'(e.id));
          chk("retire_resp", int'(retire_resp), int'(e.resp));
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] a;
    checks = 0;
    errors = 0;
    rst_n  = 0;
    drive_idle_inputs();
    model_reset();
    #12 check_reset();
    @(negedge clk);
    #3 rst_n = 1;

    // In-order allocate/complete/retire with IDs 5,6,7.
    cyc(1, 4'd5, 0, 0, 4'd0, 2'd0, 1);
    cyc(1, 4'd6, 0, 0, 4'd0, 2'd0, 1);
    cyc(1, 4'd7, 0, 0, 4'd0, 2'd0, 1);
    cyc(0, 4'd0, 1, 1, 4'd0, 2'd0, 1);
    cyc(0, 4'd0, 1, 1, 4'd1, 2'd0, 1);
    cyc(0, 4'd0, 1, 1, 4'd2, 2'd0, 1);
    idle(4, 1);

    // Out-of-order completion: younger tag done first must wait.
    a = m_next;
    cyc(1, 4'd1, 0, 0, 4'd0, 2'd0, 1);
    cyc(1, 4'd2, 0, 0, 4'd0, 2'd0, 1);
    cyc(0, 4'd0, 1, 1, a + 4'd1, 2'd0, 1);
    idle(1, 1);
    cyc(0, 4'd0, 1, 1, a, 2'd0, 1);
    idle(4, 1);

    // Fill to full with request held, then retire one to reopen.
    for (int k = 0; k < 17; k++) cyc(1, 4'($urandom), 0, 0, 4'd0, 2'd0, 1);
    cyc(1, 4'd3, 1, 1, m_q[0].tag, 2'd0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 4'd4, 0, 0, 4'd0, 2'd0, 1);
    drain();

    // Burst resp accumulation.
    a = m_next;
    cyc(1, 4'd9, 0, 0, 4'd0, 2'd0, 1);
    cyc(0, 4'd0, 1, 0, a, 2'd0, 1);
    cyc(0, 4'd0, 1, 0, a, 2'd2, 1);
    cyc(0, 4'd0, 1, 0, a, 2'd0, 1);
    cyc(0, 4'd0, 1, 1, a, 2'd0, 1);
    cyc(1, 4'd10, 0, 0, 4'd0, 2'd0, 1);
    cyc(0, 4'd0, 1, 0, a + 4'd1, 2'd1, 1);
    cyc(0, 4'd0, 1, 1, a + 4'd1, 2'd3, 1);
    idle(4, 1);

    // Backpressure with several done tags queued.
    a = m_next;
    for (int k = 0; k < 4; k++) cyc(1, 4'(k + 8), 0, 0, 4'd0, 2'd0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 4'd0, 1, 1, a + 4'(k), 2'(k), 0);
    idle(6, 0);
    idle(6, 1);

    // Completion to a free tag.
    drain();
    cyc(0, 4'd0, 1, 1, 4'd9, 2'd3, 1);
    idle(2, 1);

    random_phase(300);
    mid_reset();
    random_phase(300);
    drain();
    chk("scoreboard_left", exp_q.size(), 0);
    chk("model_inflight_left", m_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
